// File: rtl/nes_bus_arb.sv
// nes_bus_arb: N-master CPU bus arbiter; CPU stalled via rdy, others use req/gnt; ARB_HOLD_LIMIT_EN adds hold-limit preemption.
// Latency: request->grant and release->cpu_rdy are 1+GUARD_CYCLES edges; the bus mux is combinational.
// Backpressure: a requester waits with req high; every ownership change passes a forced-read guard window.
module nes_bus_arb #(
    parameter int NUM_MASTERS  = 3,
    parameter int AW           = 16,
    parameter int DW           = 8,
    parameter int PRIO_MODE    = 0,
    parameter int GUARD_CYCLES = 1,
    parameter int MAX_HOLD     = 256
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_MASTERS-1:0]    req_in,
    input  logic [NUM_MASTERS*AW-1:0] m_a_in,
    input  logic [NUM_MASTERS-1:0]    m_r_nw_in,
    input  logic [NUM_MASTERS*DW-1:0] m_d_in,
    output logic [NUM_MASTERS-1:0]    gnt_out,
    output logic                      cpu_rdy_out,
    output logic [AW-1:0]             bus_a_out,
    output logic                      bus_r_nw_out,
    output logic [DW-1:0]             bus_d_out,
    output logic [2:0]                owner_out
);
    typedef enum logic [1:0] {CPU_OWN, GUARD, M_OWN} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             owner, owner_nxt, rr_ptr, rr_ptr_nxt, rel_ptr, sel;
    logic [3:0]             guard_cnt, guard_cnt_nxt;
    logic [NUM_MASTERS-1:0] gnt_nxt, own_oh, req_m, pending;
    logic                   cpu_rdy_nxt, release_now, preempt;
    logic [AW-1:0]          last_a;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
`else
    logic unused_hold;
    assign unused_hold = (MAX_HOLD > 0);
`endif

    // Fixed mode scans 1..N-1; round-robin starts at ptr and wraps back to 1.
    function automatic logic [2:0] pick(input logic [NUM_MASTERS-1:0] r, input logic [2:0] ptr);
        logic [2:0]             w;
        logic                   found;
        logic [NUM_MASTERS-1:0] sh;
        int                     idx;
        w     = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS - 1; i++) begin
            if (PRIO_MODE == 0) idx = i + 1;
            else                idx = ((int'(ptr) - 1 + i) % (NUM_MASTERS - 1)) + 1;
            sh = r >> idx;
            if (!found && sh[0]) begin
                w     = 3'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        req_m    = req_in;
        req_m[0] = 1'b0;
        own_oh   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) own_oh[k] = (owner == 3'(k));
        pending  = req_m & ~own_oh;
        rel_ptr  = (owner == 3'(NUM_MASTERS - 1)) ? 3'd1 : owner + 3'd1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= CPU_OWN;
            owner       <= 3'd0;
            rr_ptr      <= 3'd1;
            guard_cnt   <= 4'd0;
            gnt_out     <= NUM_MASTERS'(1);
            cpu_rdy_out <= 1'b1;
            last_a      <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_ptr_nxt;
            guard_cnt   <= guard_cnt_nxt;
            gnt_out     <= gnt_nxt;
            cpu_rdy_out <= cpu_rdy_nxt;
            if (state != GUARD) last_a <= bus_a_out;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt    <= hold_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        guard_cnt_nxt = guard_cnt;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_nxt  = hold_cnt;
        preempt       = (hold_cnt >= HW'(MAX_HOLD - 1)) && (|pending);
`else
        preempt       = 1'b0;
`endif
        release_now   = ~(|(req_in & own_oh)) | preempt;
        case (state)
            CPU_OWN: begin
                if (|req_m) begin
                    state_nxt     = GUARD;
                    owner_nxt     = pick(req_m, rr_ptr);
                    guard_cnt_nxt = 4'd0;
                end
            end
            GUARD: begin
                if (guard_cnt == 4'(GUARD_CYCLES - 1)) begin
                    state_nxt    = (owner == 3'd0) ? CPU_OWN : M_OWN;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_nxt = '0;
`endif
                end else begin
                    guard_cnt_nxt = guard_cnt + 4'd1;
                end
            end
            M_OWN: begin
                if (release_now) begin
                    state_nxt     = GUARD;
                    rr_ptr_nxt    = rel_ptr;
                    owner_nxt     = (|pending) ? pick(pending, rel_ptr) : 3'd0;
                    guard_cnt_nxt = 4'd0;
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (hold_cnt < HW'(MAX_HOLD - 1)) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
`endif
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

    always_comb begin
        gnt_nxt     = '0;
        cpu_rdy_nxt = (state_nxt == CPU_OWN);
        if (state_nxt == CPU_OWN) begin
            gnt_nxt[0] = 1'b1;
        end else if (state_nxt == M_OWN) begin
            for (int k = 1; k < NUM_MASTERS; k++) gnt_nxt[k] = (owner_nxt == 3'(k));
        end
    end

    // Guard window forces a read with zero data at the last driven address.
    always_comb begin
        bus_a_out    = last_a;
        bus_r_nw_out = 1'b1;
        bus_d_out    = '0;
        sel          = (state == M_OWN) ? owner : 3'd0;
        if (state != GUARD) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (sel == 3'(k)) begin
                    bus_a_out    = m_a_in[k*AW +: AW];
                    bus_r_nw_out = m_r_nw_in[k];
                    bus_d_out    = m_d_in[k*DW +: DW];
                end
            end
        end
    end

    assign owner_out = owner;
endmodule

// File: tb/tb_nes_bus_arb.sv
// Bench for nes_bus_arb: fixed-priority, round-robin and long-guard instances checked against a per-cycle scoreboard.
module tb_nes_bus_arb;
    typedef struct {logic [3:0] gnt; logic rdy; logic [2:0] own;} exp_t;
    typedef struct {logic [3:0] req; logic [3:0] gnt; logic rdy; logic [2:0] own;} row_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    logic [2:0]  a_req, a_rnw, a_gnt, a_own;
    logic [47:0] a_addr;
    logic [23:0] a_din;
    logic [15:0] a_bus_a;
    logic [7:0]  a_bus_d;
    logic        a_rdy, a_bus_rnw;

    logic [3:0]  b_req, b_rnw, b_gnt;
    logic [2:0]  b_own;
    logic [63:0] b_addr;
    logic [31:0] b_din;
    logic [15:0] b_bus_a;
    logic [7:0]  b_bus_d;
    logic        b_rdy, b_bus_rnw;

    logic [2:0]  c_req, c_rnw, c_gnt, c_own;
    logic [47:0] c_addr;
    logic [23:0] c_din;
    logic [15:0] c_bus_a;
    logic [7:0]  c_bus_d;
    logic        c_rdy, c_bus_rnw;

    nes_bus_arb #(.NUM_MASTERS(3), .PRIO_MODE(0), .GUARD_CYCLES(1), .MAX_HOLD(8)) dut_a (
        .clk_in(clk), .rst_in(rst), .req_in(a_req), .m_a_in(a_addr), .m_r_nw_in(a_rnw),
        .m_d_in(a_din), .gnt_out(a_gnt), .cpu_rdy_out(a_rdy), .bus_a_out(a_bus_a),
        .bus_r_nw_out(a_bus_rnw), .bus_d_out(a_bus_d), .owner_out(a_own));

    nes_bus_arb #(.NUM_MASTERS(4), .PRIO_MODE(1), .GUARD_CYCLES(1)) dut_b (
        .clk_in(clk), .rst_in(rst), .req_in(b_req), .m_a_in(b_addr), .m_r_nw_in(b_rnw),
        .m_d_in(b_din), .gnt_out(b_gnt), .cpu_rdy_out(b_rdy), .bus_a_out(b_bus_a),
        .bus_r_nw_out(b_bus_rnw), .bus_d_out(b_bus_d), .owner_out(b_own));

    nes_bus_arb #(.NUM_MASTERS(3), .PRIO_MODE(0), .GUARD_CYCLES(3)) dut_c (
        .clk_in(clk), .rst_in(rst), .req_in(c_req), .m_a_in(c_addr), .m_r_nw_in(c_rnw),
        .m_d_in(c_din), .gnt_out(c_gnt), .cpu_rdy_out(c_rdy), .bus_a_out(c_bus_a),
        .bus_r_nw_out(c_bus_rnw), .bus_d_out(c_bus_d), .owner_out(c_own));

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic run_a(input string name, input row_t rows[$]);
        exp_t e;
        foreach (rows[i]) begin
            a_req = rows[i].req[2:0];
            sb.push_back('{rows[i].gnt, rows[i].rdy, rows[i].own});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (a_gnt !== e.gnt[2:0]) begin
                fails++;
                $display("FAIL %s gnt row %0d: got %b want %b", name, i, a_gnt, e.gnt[2:0]);
            end
            checks++;
            if (a_rdy !== e.rdy) begin
                fails++;
                $display("FAIL %s cpu_rdy row %0d: got %b want %b", name, i, a_rdy, e.rdy);
            end
            checks++;
            if (a_own !== e.own) begin
                fails++;
                $display("FAIL %s owner row %0d: got %0d want %0d", name, i, a_own, e.own);
            end
        end
    endtask

    task automatic test_reset();
        row_t rows[$];
        rst = 1'b1;
        a_req = 3'b110; b_req = '0; c_req = '0;
        @(negedge clk);
        checks++;
        if ({a_gnt, a_rdy, a_own} !== {3'b001, 1'b1, 3'd0}) begin
            fails++;
            $display("FAIL reset_a: got gnt=%b rdy=%b own=%0d want 001/1/0", a_gnt, a_rdy, a_own);
        end
        checks++;
        if ({b_gnt, b_rdy, b_own} !== {4'b0001, 1'b1, 3'd0}) begin
            fails++;
            $display("FAIL reset_b: got gnt=%b rdy=%b own=%0d want 0001/1/0", b_gnt, b_rdy, b_own);
        end
        checks++;
        if ({c_gnt, c_rdy, c_own} !== {3'b001, 1'b1, 3'd0}) begin
            fails++;
            $display("FAIL reset_c: got gnt=%b rdy=%b own=%0d want 001/1/0", c_gnt, c_rdy, c_own);
        end
        rst = 1'b0;
        rows.push_back('{4'b0110, 4'b0000, 1'b0, 3'd1});
        rows.push_back('{4'b0110, 4'b0010, 1'b0, 3'd1});
        run_a("reset_release", rows);
    endtask

    task automatic test_write_release();
        exp_t e;
        a_addr[0 +: 16]  = 16'h1234;
        a_addr[16 +: 16] = 16'h0300;
        a_rnw[1]         = 1'b0;
        a_din[8 +: 8]    = 8'h5A;
        #1;
        checks++;
        if ({a_bus_a, a_bus_rnw, a_bus_d} !== {16'h0300, 1'b0, 8'h5A}) begin
            fails++;
            $display("FAIL write_bus: got a=%h rnw=%b d=%h want 0300/0/5a", a_bus_a, a_bus_rnw, a_bus_d);
        end
        a_req = 3'b000;
        sb.push_back('{4'b0000, 1'b0, 3'd0});
        sb.push_back('{4'b0001, 1'b1, 3'd0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({1'b0, a_gnt, a_rdy, a_own} !== {e.gnt, e.rdy, e.own}) begin
            fails++;
            $display("FAIL release_guard: got gnt=%b rdy=%b own=%0d", a_gnt, a_rdy, a_own);
        end
        checks++;
        if ({a_bus_a, a_bus_rnw, a_bus_d} !== {16'h0300, 1'b1, 8'h00}) begin
            fails++;
            $display("FAIL guard_bus: got a=%h rnw=%b d=%h want 0300/1/00", a_bus_a, a_bus_rnw, a_bus_d);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({1'b0, a_gnt, a_rdy, a_own} !== {e.gnt, e.rdy, e.own}) begin
            fails++;
            $display("FAIL release_cpu: got gnt=%b rdy=%b own=%0d want 001/1/0", a_gnt, a_rdy, a_own);
        end
        checks++;
        if (a_bus_a !== 16'h1234) begin
            fails++;
            $display("FAIL cpu_bus_a: got %h want 1234", a_bus_a);
        end
        a_rnw[1] = 1'b1;
    endtask

    task automatic test_fixed_priority();
        row_t rows[$];
        rows.push_back('{4'b0100, 4'b0000, 1'b0, 3'd2});
        rows.push_back('{4'b0100, 4'b0100, 1'b0, 3'd2});
        rows.push_back('{4'b0110, 4'b0100, 1'b0, 3'd2});
        rows.push_back('{4'b0010, 4'b0000, 1'b0, 3'd1});
        rows.push_back('{4'b0010, 4'b0010, 1'b0, 3'd1});
        rows.push_back('{4'b0000, 4'b0000, 1'b0, 3'd0});
        rows.push_back('{4'b0000, 4'b0001, 1'b1, 3'd0});
        run_a("handover", rows);
        rows.delete();
        rows.push_back('{4'b0100, 4'b0000, 1'b0, 3'd2});
        rows.push_back('{4'b0000, 4'b0100, 1'b0, 3'd2});
        rows.push_back('{4'b0000, 4'b0000, 1'b0, 3'd0});
        rows.push_back('{4'b0000, 4'b0001, 1'b1, 3'd0});
        run_a("drop_in_guard", rows);
    endtask

    task automatic test_reset_mid_grant();
        row_t rows[$];
        exp_t e;
        rows.push_back('{4'b0100, 4'b0000, 1'b0, 3'd2});
        rows.push_back('{4'b0100, 4'b0100, 1'b0, 3'd2});
        run_a("pre_reset", rows);
        rst = 1'b1;
        sb.push_back('{4'b0001, 1'b1, 3'd0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({1'b0, a_gnt, a_rdy, a_own} !== {e.gnt, e.rdy, e.own}) begin
            fails++;
            $display("FAIL mid_reset: got gnt=%b rdy=%b own=%0d want 001/1/0", a_gnt, a_rdy, a_own);
        end
        rst = 1'b0;
        a_req = 3'b000;
        sb.push_back('{4'b0001, 1'b1, 3'd0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({1'b0, a_gnt, a_rdy, a_own} !== {e.gnt, e.rdy, e.own}) begin
            fails++;
            $display("FAIL post_reset: got gnt=%b rdy=%b own=%0d want 001/1/0", a_gnt, a_rdy, a_own);
        end
    endtask

    task automatic test_round_robin();
        row_t rows[$];
        exp_t e;
        logic [3:0] drop [3] = '{4'b1100, 4'b1010, 4'b0110};
        logic [3:0] next_gnt [3] = '{4'b0100, 4'b1000, 4'b0010};
        logic [2:0] next_own [3] = '{3'd2, 3'd3, 3'd1};
        rows.push_back('{4'b1110, 4'b0000, 1'b0, 3'd1});
        for (int r = 0; r < 4; r++) rows.push_back('{4'b1110, 4'b0010, 1'b0, 3'd1});
        for (int s = 0; s < 3; s++) begin
            rows.push_back('{drop[s], 4'b0000, 1'b0, next_own[s]});
            for (int r = 0; r < 4; r++) rows.push_back('{4'b1110, next_gnt[s], 1'b0, next_own[s]});
        end
        rows.push_back('{4'b0000, 4'b0000, 1'b0, 3'd0});
        rows.push_back('{4'b0000, 4'b0001, 1'b1, 3'd0});
        foreach (rows[i]) begin
            b_req = rows[i].req;
            sb.push_back('{rows[i].gnt, rows[i].rdy, rows[i].own});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({b_gnt, b_rdy, b_own} !== {e.gnt, e.rdy, e.own}) begin
                fails++;
                $display("FAIL round_robin row %0d: got gnt=%b rdy=%b own=%0d want gnt=%b rdy=%b own=%0d",
                         i, b_gnt, b_rdy, b_own, e.gnt, e.rdy, e.own);
            end
        end
    endtask

    task automatic test_guard3();
        row_t rows[$];
        exp_t e;
        logic [7:0] want_d;
        logic       want_rnw;
        c_addr[0 +: 16]  = 16'h0100; c_din[0 +: 8] = 8'h77;
        c_addr[16 +: 16] = 16'h0ABC; c_din[8 +: 8] = 8'hA5; c_rnw[1] = 1'b0;
        for (int r = 0; r < 3; r++) rows.push_back('{4'b0010, 4'b0000, 1'b0, 3'd1});
        rows.push_back('{4'b0010, 4'b0010, 1'b0, 3'd1});
        for (int r = 0; r < 3; r++) rows.push_back('{4'b0000, 4'b0000, 1'b0, 3'd0});
        rows.push_back('{4'b0000, 4'b0001, 1'b1, 3'd0});
        foreach (rows[i]) begin
            c_req = rows[i].req[2:0];
            sb.push_back('{rows[i].gnt, rows[i].rdy, rows[i].own});
            @(negedge clk);
            e = sb.pop_front();
            want_d   = e.gnt[1] ? 8'hA5 : (e.gnt[0] ? 8'h77 : 8'h00);
            want_rnw = ~e.gnt[1];
            checks++;
            if ({1'b0, c_gnt, c_rdy, c_own} !== {e.gnt, e.rdy, e.own}) begin
                fails++;
                $display("FAIL guard3 row %0d: got gnt=%b rdy=%b own=%0d want gnt=%b rdy=%b own=%0d",
                         i, c_gnt, c_rdy, c_own, e.gnt[2:0], e.rdy, e.own);
            end
            checks++;
            if ({c_bus_d, c_bus_rnw} !== {want_d, want_rnw}) begin
                fails++;
                $display("FAIL guard3_bus row %0d: got d=%h rnw=%b want d=%h rnw=%b",
                         i, c_bus_d, c_bus_rnw, want_d, want_rnw);
            end
            if (i < 3) begin
                checks++;
                if (c_bus_a !== 16'h0100) begin
                    fails++;
                    $display("FAIL guard3_addr row %0d: got %h want 0100", i, c_bus_a);
                end
            end
        end
        c_rnw[1] = 1'b1;
    endtask

`ifdef ARB_HOLD_LIMIT_EN
    task automatic test_hold_limit();
        row_t rows[$];
        rows.push_back('{4'b0010, 4'b0000, 1'b0, 3'd1});
        for (int r = 0; r < 8; r++) rows.push_back('{4'b0110, 4'b0010, 1'b0, 3'd1});
        rows.push_back('{4'b0110, 4'b0000, 1'b0, 3'd2});
        for (int r = 0; r < 3; r++) rows.push_back('{4'b0110, 4'b0100, 1'b0, 3'd2});
        rows.push_back('{4'b0010, 4'b0000, 1'b0, 3'd1});
        rows.push_back('{4'b0010, 4'b0010, 1'b0, 3'd1});
        rows.push_back('{4'b0000, 4'b0000, 1'b0, 3'd0});
        rows.push_back('{4'b0000, 4'b0001, 1'b1, 3'd0});
        run_a("hold_limit", rows);
    endtask
`endif

    initial begin
        a_addr = '0; a_rnw = '1; a_din = '0;
        b_addr = '0; b_rnw = '1; b_din = '0;
        c_addr = '0; c_rnw = '1; c_din = '0;
        test_reset();
        test_write_release();
        test_fixed_priority();
        test_reset_mid_grant();
        test_round_robin();
        test_guard3();
`ifdef ARB_HOLD_LIMIT_EN
        test_hold_limit();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/nes_bus_arb.md
Name: nes_bus_arb

Overview:
- Parametrised arbiter for the CPU memory bus. It replaces the fixed two-way CPU/HCI mux with an N-master arbiter.
- Master 0 is always the RP2A03 and is stalled through its rdy input. Masters 1..NUM_MASTERS-1 (HCI debugger, DMA engines, future host loaders) request the bus with a req/gnt handshake.
- Ownership changes pass through a forced-read guard window, so no master ever sees a partially driven write.
- Sits between the masters and the address decode / slave data OR-bus.

Parameters:
- NUM_MASTERS, 3, total masters including CPU (2..8).
- AW, 16, address width.
- DW, 8, data width.
- PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin among masters 1..N-1.
- GUARD_CYCLES, 1, forced-read cycles on every ownership change (1..15).
- MAX_HOLD, 256, cycle limit for one grant; used only with ARB_HOLD_LIMIT_EN.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- req_in  in  NUM_MASTERS  bus request; bit 0 is ignored (CPU is implicit default owner).
- m_a_in  in  NUM_MASTERS*AW  per-master address, master k at [k*AW +: AW].
- m_r_nw_in  in  NUM_MASTERS  per-master read/not-write.
- m_d_in  in  NUM_MASTERS*DW  per-master write data.
- gnt_out  out  NUM_MASTERS  one-hot grant; all zero during guard window.
- cpu_rdy_out  out  1  high only while master 0 owns the bus.
- bus_a_out  out  AW  muxed address.
- bus_r_nw_out  out  1  muxed read/not-write.
- bus_d_out  out  DW  muxed write data.
- owner_out  out  3  index of current/next owner (debug).

Behaviour:
- Clock and reset: one clock, clk_in; rst_in is synchronous and active-high, sampled on the rising edge.
- Reset values: state CPU_OWN, gnt_out = 1, cpu_rdy_out = 1, owner_out = 0, guard counter 0, RR pointer = 1, hold counter 0.
- Reset mid-grant: at that edge the bus returns to master 0 with no guard window.
- States: CPU_OWN, GUARD, M_OWN. All outputs are registered except the bus mux, which is combinational from the registered owner and state.
- CPU_OWN -> GUARD:
  - Taken when any req_in[k], k >= 1, is sampled high.
  - Winner: PRIO_MODE 0 picks the lowest k. PRIO_MODE 1 picks the first k at or after the RR pointer, wrapping from N-1 to 1.
  - Winner is latched into owner_out.
  - cpu_rdy_out and gnt_out[0] fall on this same edge.
- GUARD:
  - Lasts exactly GUARD_CYCLES cycles; gnt_out = 0.
  - Bus drives bus_r_nw_out = 1, bus_a_out held at the last address, bus_d_out = 0.
  - Exit goes to M_OWN if the target is k >= 1, or to CPU_OWN if the target is 0.
- M_OWN(k):
  - gnt_out[k] = 1; bus outputs come from master k.
  - Master k may assert m_r_nw_in low only while gnt_out[k] is high.
  - Grant holds while req_in[k] stays high.
- On req_in[k] low in M_OWN:
  - RR pointer becomes k+1, wrapping to 1.
  - If another req is pending, arbitrate it, latch the new owner and enter GUARD.
  - Otherwise target master 0 and enter GUARD.
  - gnt_out[k] falls on that edge.
- A request dropped during GUARD before its grant is still granted. That master then holds the grant for at least 1 cycle before release is observed.
- Simultaneous requests: resolved only by PRIO_MODE. req_in is never queued; it is level-sampled.
- Latency:
  - Request to grant: 1 + GUARD_CYCLES edges.
  - Release to cpu_rdy_out high: 1 + GUARD_CYCLES edges.
- Invalid winner: an index >= NUM_MASTERS is never generated.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - Hold counter counts cycles in M_OWN and resets on each grant.
  - When it reaches MAX_HOLD and another master's req (k >= 1) is pending, the current owner is preempted and treated exactly as a release.
  - The preempted master's req is re-arbitrated normally afterwards.
- Undefined: no hold counter or preemption logic; MAX_HOLD is ignored.

Test Plan:
- Reset with req_in = 3'b110 held -> after reset release, gnt_out = 001 for 1 cycle, then 000 for GUARD_CYCLES = 1 cycle, then gnt_out = 010 (fixed mode); cpu_rdy_out = 0 from first edge.
- Master 1 owns and writes 8'h5A to 16'h0300, then drops req -> bus_r_nw_out = 1 during guard, then gnt_out = 001 and cpu_rdy_out = 1 exactly 2 edges after the drop.
- PRIO_MODE = 1, NUM_MASTERS = 4, req_in = 4'b1110 held, each owner releasing after 4 cycles -> grant order 1, 2, 3, 1.
- rst_in asserted while master 2 owns -> next edge gnt_out = 001, cpu_rdy_out = 1, owner_out = 0, no guard window.
- GUARD_CYCLES = 3 -> measured request-to-grant = 4 edges; bus_d_out = 0 throughout the guard.
- ARB_HOLD_LIMIT_EN, MAX_HOLD = 8, master 1 holds req while master 2 requests -> master 1 preempted after 8 owned cycles, master 2 granted after the guard, then master 1 regranted when master 2 releases.
